mstart_sync_gen: RTL and testbench
==================================

Name: mstart_sync_gen

Overview:
Master-start sync transmitter. It drives the rst/sync0/sync1/sync2 strobes consumed by cntr_module, which is the receiving end of this interface. On a start command it emits a receiver-reset burst, then a periodic frame of three single-cycle sync pulses. sync0 marks the frame start; sync1 and sync2 follow at programmable offsets. It sits in the master timing block, one instance per sync fan-out.

Parameters:
PW, 16, width of period/offset counters
RST_LEN, 4, cycles rst_o is held high before the first frame
MIN_PER, 2, minimum effective frame period in cycles

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
start_i  in  1  start request; accepted only when ready_o=1
stop_i  in  1  stop request; the current frame completes, then IDLE
period_i  in  PW  frame period in clk cycles, latched on start accept
dly1_i  in  PW  sync1 offset from sync0, latched on start accept
dly2_i  in  PW  sync2 offset from sync0, latched on start accept
ready_o  out  1  high in IDLE only
busy_o  out  1  high in RST and RUN
rst_o  out  1  receiver reset strobe (to cntr_module rst)
sync0_o  out  1  frame-start pulse
sync1_o  out  1  offset pulse 1
sync2_o  out  1  offset pulse 2
frame_cnt_o  out  32  frames started since the last start accept, wraps at 2^32

Behaviour:
- Reset (rstb=0, async): state=IDLE. ready_o=1, all other outputs 0, frame_cnt_o=0, cnt=0, stop_pend=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, RST, RUN.
- IDLE:
  - start_i=1 and stop_i=0 at edge N: latch per_q=max(period_i,MIN_PER), d1_q=dly1_i, d2_q=dly2_i.
  - Clear frame_cnt_o and go to RST; rst_o=1 from cycle N+1.
  - start_i and stop_i both high in IDLE: stop wins, request ignored.
- RST:
  - rst_o held high for exactly RST_LEN cycles, then go to RUN.
  - sync0_o=1 in the first cycle rst_o=0, with cnt=0 in that cycle.
- RUN:
  - cnt increments every cycle and wraps per_q-1 -> 0.
  - sync0_o=1 exactly when cnt==0; frame_cnt_o increments in that same cycle.
  - sync1_o=1 exactly when cnt==d1_q; sync2_o=1 exactly when cnt==d2_q.
  - Offset 0: pulse coincides with sync0.
  - Offset >= per_q: that pulse never fires; no error is flagged.
- stop_i pulse in RST or RUN sets stop_pend (sticky).
  - In RUN, when cnt==per_q-1 and stop_pend=1: next state IDLE, so no further sync0 is issued.
  - Pulses scheduled in the final frame still fire.
  - In RST, the RST burst completes, then IDLE without any sync pulse.
- start_i outside IDLE is ignored; config is not re-latched.
- period_i < MIN_PER is clamped to MIN_PER. With period 2, sync0 fires every other cycle.
- rstb asserted mid-frame: immediate return to IDLE, all strobes low in the same instant.

Optional Feature:
MSTART_BURST_EN
- Defined: adds input burst_i[15:0], latched on start accept.
  - burst_i=N>0: after N sync0 pulses, the block returns to IDLE at the end of frame N, as if stop_i had been asserted.
  - burst_i=0: free-running.
- Undefined: no burst_i port; free-running until stop_i.

Decomposition:
- Package mstart_pkg:
  - state_t enum {IDLE, RST, RUN}
  - PW_DEF=16, RST_LEN_DEF=4, MIN_PER_DEF=2
  - function clamp_period
- Sub-module mstart_tap (one instance per sync1/sync2):
  - Inputs: cnt, dly, run.
  - Output: registered pulse when run && cnt==dly.
- sync0 is generated in the top level.

Test Plan:
- Reset with start held high -> all strobes 0, ready_o=1; nothing happens until the first edge after rstb release.
- period=10, dly1=3, dly2=7, start: rst_o high 4 cycles; sync0 at t0, sync1 at t0+3, sync2 at t0+7, sync0 again at t0+10; frame_cnt 1 then 2.
- Same config, stop_i at cnt=5 of frame 3: sync2 still fires at cnt=7; no frame 4; ready_o=1 one cycle after cnt=9.
- period=1, dly1=0, dly2=5: clamped to 2; sync0 and sync1 on the same cycles every 2 cycles; sync2 never fires.
- start and stop together in IDLE -> no state change. start in RUN with new period=20 -> period stays 10.
- MSTART_BURST_EN, burst=3, period=4: exactly 3 sync0 pulses, frame_cnt_o=3, then IDLE. rstb low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/mstart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mstart_pkg
//  Description : Shared types, default parameters and helpers for the
//                master-start sync transmitter (mstart_sync_gen).
//                Contents:
//                  state_t        - transmitter FSM state encoding
//                  PW_DEF         - default counter width
//                  RST_LEN_DEF    - default receiver-reset burst length
//                  MIN_PER_DEF    - default minimum frame period
//                  clamp_period() - lower-bounds a requested frame period
//  Revision    : 1.0 - initial release
// ============================================================================
package mstart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int PW_DEF      = 16;
  localparam int RST_LEN_DEF = 4;
  localparam int MIN_PER_DEF = 2;

  // Periods are handled as 32-bit values here, so counter widths up to
  // 32 bits are supported by the callers.
  function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                               input logic [31:0] min_per);
    return (period < min_per) ? min_per : period;
  endfunction

endpackage : mstart_pkg
`default_nettype wire

// File: rtl/mstart_tap.sv
`default_nettype none
// ============================================================================
//  Module      : mstart_tap
//  Description : Offset pulse tap. Emits a one-cycle registered pulse in the
//                cycle where the frame counter equals the programmed offset.
//                The parent feeds the *next* counter value and *next* run
//                flag so the pulse lines up with the registered counter.
//  Ports       :
//    clk   in   system clock
//    rstb  in   asynchronous active-low reset
//    cnt   in   next-cycle frame counter value
//    dly   in   programmed offset
//    run   in   next-cycle RUN indication
//    pulse out  registered offset pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mstart_tap
  import mstart_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [PW-1:0] cnt,
  input  logic [PW-1:0] dly,
  input  logic          run,
  output logic          pulse
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pulse <= 1'b0;
    end else begin
      pulse <= run && (cnt == dly);
    end
  end

endmodule : mstart_tap
`default_nettype wire

// File: rtl/mstart_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mstart_sync_gen
//  Description : Master-start sync transmitter. On an accepted start it
//                drives a receiver-reset burst of RST_LEN cycles on rst_o,
//                then a periodic frame: sync0_o at frame start (cnt==0),
//                sync1_o / sync2_o at the latched offsets. A stop request is
//                remembered and honoured at the end of the current frame
//                (or at the end of the reset burst).
//  Build macro : MSTART_BURST_EN - adds burst_i; a non-zero burst count
//                ends the run after that many frames.
//  Ports       :
//    clk          in   system clock
//    rstb         in   asynchronous active-low reset
//    start_i      in   start request (accepted only in IDLE)
//    stop_i       in   stop request
//    period_i     in   frame period, latched on start accept
//    dly1_i       in   sync1 offset, latched on start accept
//    dly2_i       in   sync2 offset, latched on start accept
//    burst_i      in   frame count limit (MSTART_BURST_EN only)
//    ready_o      out  high in IDLE
//    busy_o       out  high in RST and RUN
//    rst_o        out  receiver reset strobe
//    sync0_o      out  frame-start pulse
//    sync1_o      out  offset pulse 1
//    sync2_o      out  offset pulse 2
//    frame_cnt_o  out  frames started since last start accept
//  Revision    : 1.0 - initial release
// ============================================================================
module mstart_sync_gen
  import mstart_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int RST_LEN = RST_LEN_DEF,
  parameter int MIN_PER = MIN_PER_DEF
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [PW-1:0] period_i,
  input  logic [PW-1:0] dly1_i,
  input  logic [PW-1:0] dly2_i,
`ifdef MSTART_BURST_EN
  input  logic [15:0]   burst_i,
`endif
  output logic          ready_o,
  output logic          busy_o,
  output logic          rst_o,
  output logic          sync0_o,
  output logic          sync1_o,
  output logic          sync2_o,
  output logic [31:0]   frame_cnt_o
);

  // Reset-burst counter width; RST_LEN must be at least 1.
  localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic [PW-1:0] per_q;
  logic [PW-1:0] d1_q;
  logic [PW-1:0] d2_q;
  logic          stop_pend;
  logic          accept;
  logic          burst_done;
  logic          run_nxt;
  logic          sync0_nxt;

`ifdef MSTART_BURST_EN
  logic [15:0]   burst_q;
  // frame_cnt_o counts sync0 pulses issued, so reaching the burst count in
  // the last cycle of a frame means this frame is the final one.
  assign burst_done = (burst_q != 16'd0) && (frame_cnt_o == {16'd0, burst_q});
`else
  assign burst_done = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // A simultaneous stop cancels the start request.
        if (start_i && !stop_i) begin
          accept    = 1'b1;
          state_nxt = RST;
          rcnt_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      RST: begin
        if (rcnt == RW'(RST_LEN - 1)) begin
          rcnt_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = stop_pend ? IDLE : RUN;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      RUN: begin
        if (cnt == per_q - PW'(1)) begin
          cnt_nxt = '0;
          if (stop_pend || burst_done) begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        rcnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so each strobe is aligned
  // with the counter value it describes.
  assign run_nxt   = (state_nxt == RUN);
  assign sync0_nxt = run_nxt && (cnt_nxt == '0);

  // --------------------------------------------------------------------------
  // Datapath, configuration capture and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt         <= '0;
      rcnt        <= '0;
      per_q       <= PW'(MIN_PER);
      d1_q        <= '0;
      d2_q        <= '0;
      stop_pend   <= 1'b0;
      frame_cnt_o <= '0;
      ready_o     <= 1'b1;
      busy_o      <= 1'b0;
      rst_o       <= 1'b0;
      sync0_o     <= 1'b0;
`ifdef MSTART_BURST_EN
      burst_q     <= '0;
`endif
    end else begin
      cnt  <= cnt_nxt;
      rcnt <= rcnt_nxt;

      if (accept) begin
        per_q       <= PW'(clamp_period(32'(period_i), 32'(MIN_PER)));
        d1_q        <= dly1_i;
        d2_q        <= dly2_i;
        frame_cnt_o <= '0;
        stop_pend   <= 1'b0;
`ifdef MSTART_BURST_EN
        burst_q     <= burst_i;
`endif
      end else begin
        if (sync0_nxt) begin
          frame_cnt_o <= frame_cnt_o + 32'd1;
        end
        // Stop is sticky while active and forgotten once back in IDLE.
        if (state_nxt == IDLE) begin
          stop_pend <= 1'b0;
        end else if (stop_i) begin
          stop_pend <= 1'b1;
        end
      end

      ready_o <= (state_nxt == IDLE);
      busy_o  <= (state_nxt != IDLE);
      rst_o   <= (state_nxt == RST);
      sync0_o <= sync0_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Offset taps
  // --------------------------------------------------------------------------
  mstart_tap #(
    .PW (PW)
  ) u_tap1 (
    .clk   (clk),
    .rstb  (rstb),
    .cnt   (cnt_nxt),
    .dly   (d1_q),
    .run   (run_nxt),
    .pulse (sync1_o)
  );

  mstart_tap #(
    .PW (PW)
  ) u_tap2 (
    .clk   (clk),
    .rstb  (rstb),
    .cnt   (cnt_nxt),
    .dly   (d2_q),
    .run   (run_nxt),
    .pulse (sync2_o)
  );

endmodule : mstart_sync_gen
`default_nettype wire

// File: tb/tb_mstart_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mstart_sync_gen
//  Description : Self-checking bench for mstart_sync_gen. A timeline model
//                (accept slot, period, stop/burst end slot) predicts every
//                output cycle; predictions are queued at each clock edge and
//                a separate monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mstart_sync_gen;

  localparam int PW      = 16;
  localparam int RST_LEN = 4;
  localparam int MIN_PER = 2;
  localparam longint INF = 64'h3fff_ffff_ffff_ffff;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start_i;
  logic          stop_i;
  logic [PW-1:0] period_i;
  logic [PW-1:0] dly1_i;
  logic [PW-1:0] dly2_i;
  logic [15:0]   burst_i;
  logic          ready_o, busy_o, rst_o, sync0_o, sync1_o, sync2_o;
  logic [31:0]   frame_cnt_o;

  always #5 clk = ~clk;

  mstart_sync_gen #(
    .PW      (PW),
    .RST_LEN (RST_LEN),
    .MIN_PER (MIN_PER)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .period_i    (period_i),
    .dly1_i      (dly1_i),
    .dly2_i      (dly2_i),
`ifdef MSTART_BURST_EN
    .burst_i     (burst_i),
`endif
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .rst_o       (rst_o),
    .sync0_o     (sync0_o),
    .sync1_o     (sync1_o),
    .sync2_o     (sync2_o),
    .frame_cnt_o (frame_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Output vector: {ready, busy, rst, sync0, sync1, sync2, frame_cnt}
  logic [37:0] sb_q[$];

  function automatic logic [37:0] vec(bit rd, bit bs, bit rs, bit s0, bit s1,
                                      bit s2, logic [31:0] fc);
    return {rd, bs, rs, s0, s1, s2, fc};
  endfunction

  function automatic logic [37:0] dut_vec();
    return {ready_o, busy_o, rst_o, sync0_o, sync1_o, sync2_o, frame_cnt_o};
  endfunction

  task automatic check(string name, logic [37:0] act, logic [37:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual={rdy%b bsy%b rst%b s0%b s1%b s2%b fc=%0d} required={rdy%b bsy%b rst%b s0%b s1%b s2%b fc=%0d}",
               name, act[37], act[36], act[35], act[34], act[33], act[32], act[31:0],
               exp[37], exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // --------------------------------------------------------------------------
  // Timeline model. Slot s = cycle following clock edge s.
  // After an accept at edge A: reset slots A..A+R-1, frame k (1-based)
  // occupies slots A+R+(k-1)P .. A+R+kP-1. The run ends at end_slot.
  // --------------------------------------------------------------------------
  longint edge_n = 0;
  bit     active = 0;
  longint m_a, m_p, m_d1, m_d2, end_slot;

  function automatic bit model_idle(longint s);
    return !active || (s >= end_slot);
  endfunction

  function automatic logic [37:0] model_out(longint s);
    longint ph, k, fc;
    if (model_idle(s)) begin
      fc = 0;
      if (active && end_slot > m_a + RST_LEN) fc = (end_slot - m_a - RST_LEN) / m_p;
      return vec(1, 0, 0, 0, 0, 0, 32'(fc));
    end
    if (s < m_a + RST_LEN) return vec(0, 1, 1, 0, 0, 0, 32'd0);
    ph = (s - m_a - RST_LEN) % m_p;
    k  = (s - m_a - RST_LEN) / m_p + 1;
    return vec(0, 1, 0, ph == 0, ph == m_d1, ph == m_d2, 32'(k));
  endfunction

  task automatic model_edge();
    longint e, d, b;
    e = edge_n;
    if (model_idle(e - 1)) begin
      if (start_i && !stop_i) begin
        active = 1;
        m_a  = e;
        m_p  = (longint'(period_i) < MIN_PER) ? MIN_PER : longint'(period_i);
        m_d1 = longint'(dly1_i);
        m_d2 = longint'(dly2_i);
`ifdef MSTART_BURST_EN
        b = longint'(burst_i);
`else
        b = 0;
`endif
        end_slot = (b != 0) ? (m_a + RST_LEN + b * m_p) : INF;
      end
    end else if (stop_i) begin
      // Honoured at the first frame boundary at or after the next edge.
      if (e + 1 <= m_a + RST_LEN) d = m_a + RST_LEN;
      else d = m_a + RST_LEN + ((e + 1 - m_a - RST_LEN + m_p - 1) / m_p) * m_p;
      if (d < end_slot) end_slot = d;
    end
    sb_q.push_back(model_out(e));
    edge_n++;
  endtask

  task automatic step(bit st, bit sp, int unsigned per, int unsigned d1,
                      int unsigned d2, int unsigned b);
    start_i  = st;
    stop_i   = sp;
    period_i = PW'(per);
    dly1_i   = PW'(d1);
    dly2_i   = PW'(d2);
    burst_i  = 16'(b);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compare one predicted cycle per falling edge.
  initial begin
    logic [37:0] exp_v;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        check($sformatf("cycle@%0t", $time), dut_vec(), exp_v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with start asserted: nothing may happen.
    rstb = 1'b0; start_i = 1'b1; stop_i = 1'b0;
    period_i = 16'd10; dly1_i = 16'd3; dly2_i = 16'd7; burst_i = 16'd0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", dut_vec(), vec(1, 0, 0, 0, 0, 0, 0));
    #2 rstb = 1'b1;
    #1 check("after_release", dut_vec(), vec(1, 0, 0, 0, 0, 0, 0));

    // period=10, dly1=3, dly2=7; start already high at first edge.
    step(1, 0, 10, 3, 7, 0);
    repeat (RST_LEN + 12) step(0, 0, 10, 3, 7, 0);
    // Start in RUN with different config: ignored.
    step(1, 0, 20, 1, 1, 0);
    // Advance to the cnt=5 cycle of frame 3, then stop.
    repeat (RST_LEN + 2 * 10 + 5 - (RST_LEN + 13)) step(0, 0, 10, 3, 7, 0);
    step(0, 1, 10, 3, 7, 0);
    repeat (10) step(0, 0, 10, 3, 7, 0);

    // Start and stop together in IDLE: no state change.
    step(1, 1, 10, 3, 7, 0);
    repeat (3) step(0, 0, 10, 3, 7, 0);

    // Period clamping: 1 -> MIN_PER, sync2 offset out of range.
    step(1, 0, 1, 0, 5, 0);
    repeat (14) step(0, 0, 1, 0, 5, 0);
    step(0, 1, 1, 0, 5, 0);
    repeat (6) step(0, 0, 1, 0, 5, 0);

    // Burst of 3 frames, period 4 (free-running when the feature is absent).
    step(1, 0, 4, 1, 2, 3);
    repeat (25) step(0, 0, 4, 1, 2, 3);
    step(0, 1, 4, 1, 2, 3);
    repeat (8) step(0, 0, 4, 1, 2, 3);

    // Asynchronous reset mid-frame.
    step(1, 0, 10, 3, 7, 0);
    repeat (RST_LEN + 6) step(0, 0, 10, 3, 7, 0);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1 check("async_reset_midframe", dut_vec(), vec(1, 0, 0, 0, 0, 0, 0));
    active = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rstb = 1'b1;
    #1 check("post_async_reset", dut_vec(), vec(1, 0, 0, 0, 0, 0, 0));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 40) == 0,
           $urandom_range(0, 12), $urandom_range(0, 13),
           $urandom_range(0, 13), $urandom_range(0, 4));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mstart_sync_gen
`default_nettype wire
